// File: rtl/sha2_pad_pkg.sv
// ============================================================================
// Package     : sha2_pad_pkg
// Description : Shared definitions for the SHA-2 message padder. It holds the
//               padder state encoding, the padding constants and the helper
//               that derives bytes-per-word from the word width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha2_pad_pkg;

   // Padder sequencing states
   typedef enum logic [2:0] {
      S_DATA  = 3'd0,   // pass message words through
      S_PAD80 = 3'd1,   // emit a standalone 0x80 word
      S_ZERO  = 3'd2,   // emit zero fill words
      S_LENHI = 3'd3,   // emit upper half of the bit-length field
      S_LENLO = 3'd4    // emit lower half of the bit-length field
   } pad_state_e;

   // Marker byte that terminates the message
   localparam logic [7:0] PAD_BYTE   = 8'h80;

   // Block position of the upper length word (the lower one follows at 15)
   localparam logic [3:0] LEN_IDX_HI = 4'd14;

   // Bytes per word for a given word width in bits
   function automatic int word_bytes(input int word_w);
      return word_w / 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha2_pad_merge.sv
// ============================================================================
// Module      : sha2_pad_merge
// Description : Combinational merge of the terminating 0x80 byte into the
//               last message word. Bytes are big-endian and MSB-aligned:
//               byte 0 is the most significant byte. Bytes below bytes_i are
//               kept, byte[bytes_i] becomes 0x80, and all later bytes are
//               zeroed. When bytes_i equals the word size the word is passed
//               unchanged.
// Ports       : data_i  - raw last message word
//               bytes_i - number of valid message bytes (0..WORD_W/8)
//               data_o  - word with 0x80 inserted and the tail cleared
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha2_pad_merge
   import sha2_pad_pkg::*;
#(
   parameter  int WORD_W     = 32,
   localparam int WORD_BYTES = word_bytes(WORD_W),
   localparam int CNT_W      = $clog2(WORD_BYTES) + 1
) (
   input  logic [WORD_W-1:0] data_i,
   input  logic [CNT_W-1:0]  bytes_i,
   output logic [WORD_W-1:0] data_o
);

   for (genvar b = 0; b < WORD_BYTES; b++) begin : g_byte
      localparam int HI = WORD_W - 1 - 8 * b;
      assign data_o[HI -: 8] = (CNT_W'(b) <  bytes_i) ? data_i[HI -: 8] :
                               (CNT_W'(b) == bytes_i) ? PAD_BYTE        :
                                                        8'h00;
   end

endmodule

`default_nettype wire

// File: rtl/sha2_msg_padder.sv
// ============================================================================
// Module      : sha2_msg_padder
// Description : SHA-2 message padder. It takes a raw big-endian word stream
//               with a last flag and a byte count. It emits the padded
//               message as 16-word blocks: message bytes, 0x80, zero fill
//               and the message bit length in words 14/15 of the last block.
//               A one-stage output register gives 1-cycle latency and full
//               valid/ready backpressure.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous reset, active low
//               in_data   - message word, valid bytes MSB-aligned
//               in_valid  - in_data valid
//               in_ready  - padder accepts in_data this cycle
//               in_last   - last word of the message
//               in_bytes  - valid bytes in the last word (0..WORD_W/8)
//               out_data  - padded word
//               out_valid - out_data valid
//               out_ready - downstream accepts out_data
//               out_first - first word of a message
//               out_last  - final word of the final block
//               len_ovf   - bit-length counter wrapped during this message
//                           (present only with SHA2_PAD_LEN_OVF_EN)
// Options     : define SHA2_PAD_LEN_OVF_EN to add the len_ovf output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha2_msg_padder
   import sha2_pad_pkg::*;
#(
   parameter  int WORD_W     = 32,
   localparam int WORD_BYTES = word_bytes(WORD_W),
   localparam int LEN_W      = 2 * WORD_W,
   localparam int CNT_W      = $clog2(WORD_BYTES) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [CNT_W-1:0]  in_bytes,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_first,
   output logic              out_last
`ifdef SHA2_PAD_LEN_OVF_EN
   ,
   output logic              len_ovf
`endif
);

   pad_state_e        state_q,      state_d;
   logic [3:0]        idx_q,        idx_d;
   logic [LEN_W-1:0]  len_q,        len_d;
   logic [WORD_W-1:0] out_data_q,   out_data_d;
   logic              out_valid_q,  out_valid_d;
   logic              out_first_q,  out_first_d;
   logic              out_last_q,   out_last_d;
   logic              first_pend_q, first_pend_d;

   logic              w_adv;
   logic              w_load;
   logic [WORD_W-1:0] w_word;
   logic              w_word_last;
   logic [WORD_W-1:0] w_merged;
   pad_state_e        w_state_nxt;
   pad_state_e        w_fill_state;
   logic [LEN_W-1:0]  w_len_nxt;
   logic [LEN_W-1:0]  w_incr;
   logic [LEN_W-1:0]  w_len_sum;

   // The output register can take a new word when empty or being drained
   assign w_adv    = !out_valid_q || out_ready;
   assign in_ready = (state_q == S_DATA) && w_adv;

   sha2_pad_merge #(
      .WORD_W (WORD_W)
   ) u_merge (
      .data_i  (in_data),
      .bytes_i (in_bytes),
      .data_o  (w_merged)
   );

   // A last word contributes only its valid bytes to the bit count
   assign w_incr = in_last ? (LEN_W'(in_bytes) << 3) : LEN_W'(WORD_W);

`ifdef SHA2_PAD_LEN_OVF_EN
   logic [LEN_W:0] w_sum;
   logic           w_carry;
   logic           len_ovf_q, len_ovf_d;

   assign w_sum     = {1'b0, len_q} + {1'b0, w_incr};
   assign w_len_sum = w_sum[LEN_W-1:0];
   assign w_carry   = w_sum[LEN_W];
`else
   assign w_len_sum = len_q + w_incr;
`endif

   // The state after a padding word is picked by looking ahead at the slot
   // the next word lands in. When that slot is the length position, the
   // zero-fill phase is empty and the length words follow at once. This
   // keeps the output stream gap-free.
   assign w_fill_state = ((idx_q + 4'd1) == LEN_IDX_HI) ? S_LENHI : S_ZERO;

   // Word to load and follow-on state, ignoring the advance condition
   always_comb begin
      w_load      = 1'b0;
      w_word      = '0;
      w_word_last = 1'b0;
      w_state_nxt = state_q;
      w_len_nxt   = len_q;
      case (state_q)
         S_DATA: begin
            if (in_valid) begin
               w_load    = 1'b1;
               w_len_nxt = w_len_sum;
               if (!in_last) begin
                  w_word = in_data;
               end else if (in_bytes < CNT_W'(WORD_BYTES)) begin
                  w_word      = w_merged;
                  w_state_nxt = w_fill_state;
               end else begin
                  w_word      = in_data;
                  w_state_nxt = S_PAD80;
               end
            end
         end
         S_PAD80: begin
            w_load      = 1'b1;
            w_word      = {PAD_BYTE, {(WORD_W-8){1'b0}}};
            w_state_nxt = w_fill_state;
         end
         S_ZERO: begin
            w_load      = 1'b1;
            w_state_nxt = w_fill_state;
         end
         S_LENHI: begin
            w_load      = 1'b1;
            w_word      = len_q[LEN_W-1:WORD_W];
            w_state_nxt = S_LENLO;
         end
         S_LENLO: begin
            w_load      = 1'b1;
            w_word      = len_q[WORD_W-1:0];
            w_word_last = 1'b1;
            w_len_nxt   = '0;
            w_state_nxt = S_DATA;
         end
         default: begin
            w_state_nxt = S_DATA;
         end
      endcase
   end

   // Register updates happen only on advance cycles; a stall freezes all
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      len_d        = len_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_first_d  = out_first_q;
      out_last_d   = out_last_q;
      first_pend_d = first_pend_q;
      if (w_adv) begin
         if (w_load) begin
            state_d      = w_state_nxt;
            idx_d        = idx_q + 4'd1;
            len_d        = w_len_nxt;
            out_data_d   = w_word;
            out_valid_d  = 1'b1;
            out_first_d  = first_pend_q;
            out_last_d   = w_word_last;
            // The word after the closing length word starts a new message
            first_pend_d = w_word_last;
         end else begin
            out_valid_d  = 1'b0;
            out_first_d  = 1'b0;
            out_last_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_DATA;
         idx_q        <= '0;
         len_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         first_pend_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_first_q  <= out_first_d;
         out_last_q   <= out_last_d;
         first_pend_q <= first_pend_d;
      end
   end

`ifdef SHA2_PAD_LEN_OVF_EN
   // Sticky carry flag; the first word of a message restarts it
   always_comb begin
      len_ovf_d = len_ovf_q;
      if (w_adv && w_load && (state_q == S_DATA)) begin
         len_ovf_d = (first_pend_q ? 1'b0 : len_ovf_q) | w_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_ovf_q <= 1'b0;
      end else begin
         len_ovf_q <= len_ovf_d;
      end
   end

   assign len_ovf = len_ovf_q;
`endif

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_sha2_msg_padder.sv
// ============================================================================
// Module      : tb_sha2_msg_padder
// Description : Self-checking bench for sha2_msg_padder at WORD_W=32 and 64.
//               The expected padded stream is built from the message bytes
//               with plain byte-queue arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha2_msg_padder;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] in_data32;
   logic        in_valid32, in_last32, out_ready32;
   logic [2:0]  in_bytes32;
   logic        in_ready32, out_valid32, out_first32, out_last32;
   logic [31:0] out_data32;

   logic [63:0] in_data64;
   logic        in_valid64, in_last64, out_ready64;
   logic [3:0]  in_bytes64;
   logic        in_ready64, out_valid64, out_first64, out_last64;
   logic [63:0] out_data64;

`ifdef SHA2_PAD_LEN_OVF_EN
   logic        len_ovf32, len_ovf64;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned msg_q[$];
   logic [63:0]  exp_q[$];

   always #5 clk = ~clk;

   sha2_msg_padder #(.WORD_W(32)) u_dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data32),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .in_last   (in_last32),
      .in_bytes  (in_bytes32),
      .out_data  (out_data32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .out_first (out_first32),
      .out_last  (out_last32)
`ifdef SHA2_PAD_LEN_OVF_EN
      ,
      .len_ovf   (len_ovf32)
`endif
   );

   sha2_msg_padder #(.WORD_W(64)) u_dut64 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data64),
      .in_valid  (in_valid64),
      .in_ready  (in_ready64),
      .in_last   (in_last64),
      .in_bytes  (in_bytes64),
      .out_data  (out_data64),
      .out_valid (out_valid64),
      .out_ready (out_ready64),
      .out_first (out_first64),
      .out_last  (out_last64)
`ifdef SHA2_PAD_LEN_OVF_EN
      ,
      .len_ovf   (len_ovf64)
`endif
   );

   // Reference: bytes, 0x80, zeros to 14 words mod 16, big-endian bit length
   task automatic build_expected(input int wb);
      byte unsigned pb[$];
      logic [127:0] bitlen;
      logic [63:0]  w;
      pb     = msg_q;
      bitlen = 128'(msg_q.size()) * 128'd8;
      pb.push_back(8'h80);
      while ((pb.size() % (16 * wb)) != (14 * wb)) pb.push_back(8'h00);
      for (int i = 2 * wb - 1; i >= 0; i--) pb.push_back(bitlen[8*i +: 8]);
      exp_q.delete();
      for (int i = 0; i < pb.size(); i += wb) begin
         w = '0;
         for (int k = 0; k < wb; k++) w = (w << 8) | 64'(pb[i+k]);
         exp_q.push_back(w);
      end
   endtask

   task automatic set_rand_msg(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
   endtask

   task automatic set_abc();
      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
   endtask

   // Feed msg_q into one DUT and score every output word against the model
   task automatic run_msg(input string name, input bit w64,
                          input int ready_pct, input int valid_pct);
      int wb     = w64 ? 8 : 4;
      int n      = msg_q.size();
      int nwords = (n == 0) ? 1 : (n + wb - 1) / wb;
      int ptr    = 0;
      int outn   = 0;
      int cyc    = 0;
      int bc;
      bit in_done = 1'b0;
      bit stall_prev = 1'b0;
      bit r, v, lst, ov, of, ol, ir, ef, el;
      logic [63:0] wd, od, ew, held_d;
      bit held_f, held_l;
      build_expected(wb);
      while (exp_q.size() != 0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         r   = ($urandom_range(99) < ready_pct);
         v   = 1'b0;
         lst = 1'b0;
         bc  = 0;
         wd  = {$urandom, $urandom};
         if (ptr < nwords && ($urandom_range(99) < valid_pct)) begin
            v   = 1'b1;
            lst = (ptr == nwords - 1);
            bc  = lst ? (n - ptr * wb) : wb;
            wd  = '0;
            // Bytes beyond the valid count are junk and must be discarded
            for (int k = 0; k < wb; k++)
               wd = (wd << 8) | 64'((ptr * wb + k < n) ? msg_q[ptr*wb+k] : 8'($urandom));
         end
         if (w64) begin
            in_valid64 = v; in_data64 = wd; in_last64 = lst;
            in_bytes64 = 4'(bc); out_ready64 = r;
         end else begin
            in_valid32 = v; in_data32 = wd[31:0]; in_last32 = lst;
            in_bytes32 = 3'(bc); out_ready32 = r;
         end
         #1;
         ov = w64 ? out_valid64 : out_valid32;
         of = w64 ? out_first64 : out_first32;
         ol = w64 ? out_last64  : out_last32;
         ir = w64 ? in_ready64  : in_ready32;
         od = w64 ? out_data64  : {32'h0, out_data32};
         if (stall_prev) begin
            n_checks++;
            if (ov !== 1'b1 || od !== held_d || of !== held_f || ol !== held_l) begin
               n_fail++;
               $display("FAIL %s stall-hold: got v=%b d=%h f=%b l=%b, expected v=1 d=%h f=%b l=%b",
                        name, ov, od, of, ol, held_d, held_f, held_l);
            end
         end
         if (in_done && !(ov && ol)) begin
            n_checks++;
            if (ir !== 1'b0) begin
               n_fail++;
               $display("FAIL %s in_ready-during-pad: got %b, expected 0", name, ir);
            end
         end
         if (ov && r) begin
            n_checks++;
            ew = exp_q.pop_front();
            ef = (outn == 0);
            el = (exp_q.size() == 0);
            if (od !== ew || of !== ef || ol !== el) begin
               n_fail++;
               $display("FAIL %s word %0d: got d=%h f=%b l=%b, expected d=%h f=%b l=%b",
                        name, outn, od, of, ol, ew, ef, el);
            end
            outn++;
         end
         if (v && ir) begin
            ptr++;
            if (ptr == nwords) in_done = 1'b1;
         end
         stall_prev = ov && !r;
         held_d = od; held_f = of; held_l = ol;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d words, expected %0d more", name, outn, exp_q.size());
      end
      if (w64) in_valid64 = 1'b0; else in_valid32 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid32 = 0; in_last32 = 0; in_bytes32 = '0; in_data32 = '0; out_ready32 = 1;
      in_valid64 = 0; in_last64 = 0; in_bytes64 = '0; in_data64 = '0; out_ready64 = 1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b0 || out_first32 !== 1'b0 || out_last32 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset32 flags: got v=%b f=%b l=%b, expected 0 0 0", out_valid32, out_first32, out_last32);
      end
      n_checks++;
      if (out_data32 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset32 data: got %h, expected 0", out_data32);
      end
      n_checks++;
      if (in_ready32 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset32 in_ready: got %b, expected 1", in_ready32);
      end
      n_checks++;
      if (out_valid64 !== 1'b0 || out_first64 !== 1'b0 || out_last64 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset64 flags: got v=%b f=%b l=%b, expected 0 0 0", out_valid64, out_first64, out_last64);
      end
      n_checks++;
      if (out_data64 !== 64'h0 || in_ready64 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset64 data/in_ready: got %h/%b, expected 0/1", out_data64, in_ready64);
      end
`ifdef SHA2_PAD_LEN_OVF_EN
      n_checks++;
      if (len_ovf32 !== 1'b0 || len_ovf64 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset len_ovf: got %b/%b, expected 0/0", len_ovf32, len_ovf64);
      end
`endif
      rst = 1'b1;
   endtask

   task automatic test_abc32();
      set_abc();
      run_msg("abc32", 1'b0, 100, 100);
   endtask

   task automatic test_empty32();
      msg_q.delete();
      run_msg("empty32", 1'b0, 100, 100);
   endtask

   task automatic test_14words32();
      set_rand_msg(56);
      run_msg("14words32", 1'b0, 100, 100);
   endtask

   task automatic test_16words32();
      set_rand_msg(64);
      run_msg("16words32", 1'b0, 100, 100);
   endtask

   task automatic test_backpressure32();
      set_rand_msg(56);
      run_msg("backpressure32", 1'b0, 50, 70);
   endtask

   // Reset in the middle of the zero fill, then the same message again
   task automatic test_abc64_reset_replay();
      bit acc = 1'b0;
      @(negedge clk);
      out_ready64 = 1'b1;
      in_valid64  = 1'b1;
      in_last64   = 1'b1;
      in_bytes64  = 4'd3;
      in_data64   = 64'h6162_6355_AA11_22FF;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         if (in_ready64) acc = 1'b1;
      end
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL abc64 accept: got in_ready=0, expected 1 within 50 cycles");
      end
      @(negedge clk);
      in_valid64 = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (out_valid64 !== 1'b1 || out_data64 !== 64'h0) begin
         n_fail++;
         $display("FAIL abc64 zero-fill: got v=%b d=%h, expected v=1 d=0", out_valid64, out_data64);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid64 !== 1'b0 || out_data64 !== 64'h0 || out_first64 !== 1'b0 ||
          out_last64 !== 1'b0 || in_ready64 !== 1'b1) begin
         n_fail++;
         $display("FAIL abc64 mid-pad reset: got v=%b d=%h f=%b l=%b rdy=%b, expected 0 0 0 0 1",
                  out_valid64, out_data64, out_first64, out_last64, in_ready64);
      end
      rst = 1'b1;
      set_abc();
      run_msg("abc64-replay", 1'b1, 100, 100);
   endtask

   // Consecutive messages with no idle gap, lengths around the block edges
   task automatic test_back_to_back();
      int lens[10] = '{55, 60, 62, 0, 119, 120, 7, 64, 111, 200};
      for (int i = 0; i < 10; i++) begin
         set_rand_msg(lens[i]);
         run_msg("b2b32", 1'b0, 30 + $urandom_range(70), 60 + $urandom_range(40));
         set_rand_msg(lens[i] + $urandom_range(8));
         run_msg("b2b64", 1'b1, 30 + $urandom_range(70), 60 + $urandom_range(40));
      end
   endtask

   task automatic test_idle();
      @(negedge clk);
      out_ready32 = 1'b1;
      out_ready64 = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
         n_fail++;
         $display("FAIL idle: got out_valid=%b/%b, expected 0/0", out_valid32, out_valid64);
      end
   endtask

   initial begin
      test_reset();
      test_abc32();
      test_empty32();
      test_14words32();
      test_16words32();
      test_backpressure32();
      test_abc64_reset_replay();
      test_back_to_back();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
